lfsr_step_ctrl: RTL
===================

Name: lfsr_step_ctrl

Overview:
Sequencing controller for the 8-bit LFSR shift register lab datapath. It debounces the raw step and run buttons and produces single-cycle step/load strobes for the external LFSR register, which shifts on lfsr_step and loads lfsr_din on lfsr_load. It supports single-step, free-run at a programmable rate, seed load and all-zero lock-up recovery. It also measures the sequence period for display on the 7-segment digits.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a button level (>=2)
RATE_W, 24, width of rate_div
SEED, 8'h01, default nonzero seed, loaded after reset, on lock-up, and when a zero seed is requested

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
btn_step  input  1  raw step button, asynchronous, bouncy
btn_run  input  1  raw run/stop toggle button, asynchronous, bouncy
rate_div  input  RATE_W  free-run interval; one step every rate_div+1 cycles
load_req  input  1  synchronous 1-cycle request to load load_val
load_val  input  8  requested seed
lfsr_q  input  8  current LFSR state, fed back from the datapath
lfsr_step  output  1  1-cycle shift strobe to LFSR
lfsr_load  output  1  1-cycle parallel-load strobe to LFSR
lfsr_din  output  8  value to load when lfsr_load=1
running  output  1  high while in RUN
period  output  8  measured period (steps from load until state returns to the loaded value)
period_valid  output  1  period holds a valid measurement
lockup  output  1  1-cycle pulse when an all-zero state is detected

Behaviour:
- Reset (rst=1 at a clk edge): all outputs 0 except lfsr_din=SEED. Synchronizers, debounce counters, rate counter and step counter are cleared; the debounced levels are 0. The FSM goes to INIT.
- Button path, applied to each button independently:
  - 2-FF synchronizer, then debounce: the debounced level takes the synchronized level after DEBOUNCE_CYCLES consecutive equal samples that differ from the current debounced level.
  - A rising edge of the debounced level gives a 1-cycle internal pulse (step_p / run_p).
  - Press-to-pulse latency is 2 + DEBOUNCE_CYCLES cycles. Releases produce nothing.
- FSM states: INIT, IDLE, RUN, LOAD, RECOVER.
  - INIT: lfsr_load=1, lfsr_din=SEED for one cycle, then IDLE.
  - IDLE: priority is load_req > run_p > step_p.
    - load_req: go to LOAD, latching load_val, or SEED if load_val==0.
    - run_p: go to RUN with the rate counter cleared.
    - step_p: lfsr_step=1 for exactly one cycle; stay in IDLE.
  - RUN: running=1. The rate counter increments each cycle.
    - When it equals rate_div: lfsr_step=1 and the counter clears. rate_div=0 means a step every cycle.
    - step_p is ignored.
    - run_p: go to IDLE with no step on that cycle.
    - load_req: go to LOAD. load_req has priority over run_p and over a rate step on the same cycle.
  - LOAD: lfsr_load=1 and lfsr_din=latched value for one cycle, then IDLE (running=0). The latched value also becomes start_val.
  - RECOVER: lfsr_load=1, lfsr_din=SEED, lockup=1 for one cycle, then IDLE. start_val=SEED.
- Lock-up detection: in IDLE or RUN, if lfsr_q==8'h00 and no load is pending in the previous cycle, go to RECOVER. This takes priority over all button and load events.
- Period measurement:
  - Every load (INIT, LOAD, RECOVER) clears step_cnt to 0 and period_valid to 0.
  - Each lfsr_step increments step_cnt, saturating at 255.
  - lfsr_q reflects a step one cycle later. On the cycle after any step, if lfsr_q==start_val and period_valid==0: period=step_cnt, period_valid=1.
  - period and period_valid hold until the next load.
  - If step_cnt saturates without a match, period_valid stays 0.
- lfsr_step and lfsr_load are never asserted in the same cycle.
- rst asserted mid-RUN or mid-debounce aborts everything; the next cycle after release is INIT.

Test Plan:
1. Reset, then release: cycle 1 gives lfsr_load=1, lfsr_din=8'h01; next state IDLE; running=0, period_valid=0.
2. btn_step with a 5-cycle bounce, then held 40 cycles (DEBOUNCE_CYCLES=16) -> exactly one lfsr_step pulse, 18 cycles after the last bounce edge; the release produces no pulse.
3. run press, rate_div=3 -> running=1 and lfsr_step every 4th cycle; a second run press gives running=0 and no further steps; btn_step during RUN gives no extra steps.
4. Bench stub: lfsr_q goes 01→02→03→01 on successive steps. load_req with load_val=8'h01, then three steps -> period=3 and period_valid=1 the cycle after the third step; a 4th step leaves period=3.
5. load_req with load_val=8'h00 -> lfsr_din=8'h01. Bench forces lfsr_q=8'h00 while in RUN -> lockup pulse, lfsr_load=1 with lfsr_din=8'h01, state IDLE, running=0, period_valid=0.
6. load_req and run_p on the same IDLE cycle -> LOAD wins, state IDLE afterwards, running=0. rst asserted mid-RUN -> all outputs 0 next cycle, then INIT load.

Source files
------------

// File: rtl/lfsr_step_ctrl.sv
// lfsr_step_ctrl: button debounce, step/run/load sequencing and period measurement for an 8-bit LFSR
module lfsr_step_ctrl #(
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter int          RATE_W          = 24,
  parameter logic [7:0]  SEED            = 8'h01
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_step,
  input  logic              btn_run,
  input  logic [RATE_W-1:0] rate_div,
  input  logic              load_req,
  input  logic [7:0]        load_val,
  input  logic [7:0]        lfsr_q,
  output logic              lfsr_step,
  output logic              lfsr_load,
  output logic [7:0]        lfsr_din,
  output logic              running,
  output logic [7:0]        period,
  output logic              period_valid,
  output logic              lockup
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_RUN, S_LOAD, S_RECOVER} state_t;
  state_t            r_state;
  logic [1:0]        w_btn, r_s1, r_s2, r_db, r_db_d;
  logic [CW-1:0]     r_cnt [2];
  logic [RATE_W-1:0] r_rate;
  logic [7:0]        r_lval, r_start, r_step_cnt;
  logic              r_ovf, r_step_d;
  logic              w_step_p, w_run_p, w_lock;
  assign w_btn    = {btn_run, btn_step};
  assign w_step_p = r_db[0] & ~r_db_d[0];
  assign w_run_p  = r_db[1] & ~r_db_d[1];
  // zero state only counts once any load in flight has landed in the LFSR
  assign w_lock   = (lfsr_q == 8'h00) && !lfsr_load;
  // synchronize both buttons, then accept a new level after DEBOUNCE_CYCLES equal samples
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_db   <= '0;
      r_db_d <= '0;
      for (int i = 0; i < 2; i++) r_cnt[i] <= '0;
    end else begin
      r_s1   <= w_btn;
      r_s2   <= r_s1;
      r_db_d <= r_db;
      for (int i = 0; i < 2; i++)
        if (r_s2[i] == r_db[i]) r_cnt[i] <= '0;
        else if (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          r_db[i]  <= r_s2[i];
          r_cnt[i] <= '0;
        end else r_cnt[i] <= r_cnt[i] + 1'b1;
    end
  end
  // sequencing FSM with registered strobes, plus step counting and period capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_INIT;
      lfsr_step    <= 1'b0;
      lfsr_load    <= 1'b0;
      lfsr_din     <= SEED;
      running      <= 1'b0;
      lockup       <= 1'b0;
      period       <= 8'h00;
      period_valid <= 1'b0;
      r_rate       <= '0;
      r_lval       <= SEED;
      r_start      <= SEED;
      r_step_cnt   <= 8'h00;
      r_ovf        <= 1'b0;
      r_step_d     <= 1'b0;
    end else begin
      lfsr_step <= 1'b0;
      lfsr_load <= 1'b0;
      lockup    <= 1'b0;
      r_step_d  <= lfsr_step;
      if (lfsr_step) begin
        r_step_cnt <= (r_step_cnt == 8'hff) ? 8'hff : r_step_cnt + 8'h01;
        r_ovf      <= r_ovf | (r_step_cnt == 8'hff);
      end
      if (r_step_d && lfsr_q == r_start && !period_valid && !r_ovf) begin
        period       <= r_step_cnt;
        period_valid <= 1'b1;
      end
      case (r_state)
        S_INIT, S_LOAD, S_RECOVER: begin
          lfsr_load    <= 1'b1;
          lfsr_din     <= (r_state == S_LOAD) ? r_lval : SEED;
          r_start      <= (r_state == S_LOAD) ? r_lval : SEED;
          lockup       <= (r_state == S_RECOVER);
          r_step_cnt   <= 8'h00;
          r_ovf        <= 1'b0;
          period_valid <= 1'b0;
          running      <= 1'b0;
          r_state      <= S_IDLE;
        end
        S_IDLE: begin
          if (w_lock) r_state <= S_RECOVER;
          else if (load_req) begin
            r_state <= S_LOAD;
            r_lval  <= (load_val == 8'h00) ? SEED : load_val;
          end else if (w_run_p) begin
            r_state <= S_RUN;
            running <= 1'b1;
            r_rate  <= '0;
          end else if (w_step_p) lfsr_step <= 1'b1;
        end
        S_RUN: begin
          if (w_lock) begin
            r_state <= S_RECOVER;
            running <= 1'b0;
          end else if (load_req) begin
            r_state <= S_LOAD;
            running <= 1'b0;
            r_lval  <= (load_val == 8'h00) ? SEED : load_val;
          end else if (w_run_p) begin
            r_state <= S_IDLE;
            running <= 1'b0;
          end else if (r_rate == rate_div) begin
            lfsr_step <= 1'b1;
            r_rate    <= '0;
          end else r_rate <= r_rate + 1'b1;
        end
        default: r_state <= S_INIT;
      endcase
    end
  end
endmodule
